// File: rtl/ping_pkg.sv
// Shared types and elaboration-time helpers for the ultrasonic ping controller.
package ping_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX,
    S_BLANK,
    S_LISTEN,
    S_GAP
  } ping_state_t;

  // The burst always spans a whole number of tone periods.
  function automatic longint burst_clks(input longint half_period, input longint cycles);
    return cycles * 2 * half_period;
  endfunction

  // True when a TOF_W-bit counter reaches worst_clks - 1 without saturating early.
  function automatic bit tof_fits(input int tof_w, input longint worst_clks);
    if (tof_w >= 62) return 1'b1;
    return (worst_clks - 1) <= ((longint'(1) << tof_w) - 1);
  endfunction

endpackage

// File: rtl/tone_divider.sv
// Half-period counter producing the transmit square wave; it restarts high
// whenever it is enabled after being idle or cleared.
module tone_divider #(
  parameter int HALF_PERIOD = 1250
) (
  input  logic clk,
  input  logic i_en,
  input  logic i_clr,
  output logic o_square
);

  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] r_cnt;
  logic          r_sq;

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values of the others, regardless of block order.
  always_ff @(posedge clk) begin
    if (i_clr || !i_en) begin
      r_cnt <= '0;
      r_sq  <= 1'b1;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
      r_sq  <= ~r_sq;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_square = i_en & r_sq;

endmodule

// File: rtl/ping_controller.sv
// One-ping sequencer: TX burst, receiver blanking, listen window, holdoff gap,
// with time-of-flight measured from the first TX cycle to the first echo.
module ping_controller
  import ping_pkg::*;
#(
  parameter int CLK_FREQ     = 100000000,
  parameter int TARGET_FREQ  = 40000,
  parameter int HALF_PERIOD  = CLK_FREQ / (2 * TARGET_FREQ),
  parameter int BURST_CYCLES = 8,
  parameter int BLANK_CLKS   = 50000,
  parameter int LISTEN_CLKS  = 2500000,
  parameter int GAP_CLKS     = 1000000,
  parameter int TOF_W        = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             continuous,
  input  logic             echo_in,
  output logic             tx_en,
  output logic             tx_square,
  output logic             rx_gate,
  output logic             busy,
  output logic             tof_valid,
  output logic [TOF_W-1:0] tof_cycles,
  output logic             no_echo
);

  localparam longint BURST_CLKS = burst_clks(longint'(HALF_PERIOD), longint'(BURST_CYCLES));
  localparam logic [31:0] BURST_LAST  = 32'(BURST_CLKS - 1);
  localparam logic [31:0] BLANK_LAST  = 32'(BLANK_CLKS - 1);
  localparam logic [31:0] LISTEN_LAST = 32'(LISTEN_CLKS - 1);
  localparam logic [31:0] GAP_LAST    = 32'(GAP_CLKS - 1);

  if (!tof_fits(TOF_W, BURST_CLKS + longint'(BLANK_CLKS) + longint'(LISTEN_CLKS))) begin : g_tof_too_narrow
    $error("ping_controller: TOF_W too narrow for TX+BLANK+LISTEN duration");
  end

  ping_state_t      r_state, w_next;
  logic [31:0]      r_phase;
  logic [TOF_W-1:0] r_tof;
  logic [TOF_W-1:0] r_tof_cycles;
  logic             r_tof_valid, r_no_echo;
  logic             w_hit, w_timeout, w_tof_load, w_in_flight, w_tx, w_square;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement leaves one unassigned and infers a latch.
  always_comb begin
    w_next    = r_state;
    w_hit     = 1'b0;
    w_timeout = 1'b0;
    unique case (r_state)
      S_IDLE:   if (start || continuous) w_next = S_TX;
      S_TX:     if (r_phase == BURST_LAST) w_next = S_BLANK;
      S_BLANK:  if (r_phase == BLANK_LAST) w_next = S_LISTEN;
      S_LISTEN: begin
        if (echo_in) begin
          w_next = S_GAP;
          w_hit  = 1'b1;
        end else if (r_phase == LISTEN_LAST) begin
          w_next    = S_GAP;
          w_timeout = 1'b1;
        end
      end
      S_GAP:    if (r_phase == GAP_LAST) w_next = continuous ? S_TX : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign w_tx        = (r_state == S_TX);
  assign w_in_flight = w_tx || (r_state == S_BLANK) || (r_state == S_LISTEN);
  assign w_tof_load  = (w_next == S_TX) && !w_tx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_phase      <= '0;
      r_tof        <= '0;
      r_tof_cycles <= '0;
      r_tof_valid  <= 1'b0;
      r_no_echo    <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_tof_valid <= w_hit;
      r_no_echo   <= w_timeout;
      // Phase restarts on every state change so each state times itself.
      if (w_next != r_state || r_state == S_IDLE) r_phase <= '0;
      else                                        r_phase <= r_phase + 32'd1;
      if (w_tof_load)                          r_tof <= '0;
      else if (w_in_flight && r_tof != '1)     r_tof <= r_tof + TOF_W'(1);
      if (w_hit) r_tof_cycles <= r_tof;
    end
  end

  tone_divider #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_tone (
    .clk      (clk),
    .i_en     (w_tx),
    .i_clr    (rst),
    .o_square (w_square)
  );

  assign tx_en      = w_tx;
  assign tx_square  = w_square;
  assign rx_gate    = (r_state == S_LISTEN);
  assign busy       = (r_state != S_IDLE);
  assign tof_valid  = r_tof_valid;
  assign no_echo    = r_no_echo;
  assign tof_cycles = r_tof_cycles;

endmodule

// File: tb/tb_ping_controller.sv
// Scoreboard bench for ping_controller: stimulus pushes hand-computed output
// events, a negedge monitor matches each observed output event against them.
module tb_ping_controller;

  localparam int TOF_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             continuous = 1'b0;
  logic             echo_in = 1'b0;
  logic             tx_en, tx_square, rx_gate, busy, tof_valid, no_echo;
  logic [TOF_W-1:0] tof_cycles;

  ping_controller #(
    .CLK_FREQ     (100),
    .TARGET_FREQ  (10),
    .BURST_CYCLES (2),
    .BLANK_CLKS   (10),
    .LISTEN_CLKS  (50),
    .GAP_CLKS     (5),
    .TOF_W        (TOF_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .continuous (continuous),
    .echo_in    (echo_in),
    .tx_en      (tx_en),
    .tx_square  (tx_square),
    .rx_gate    (rx_gate),
    .busy       (busy),
    .tof_valid  (tof_valid),
    .tof_cycles (tof_cycles),
    .no_echo    (no_echo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {
    EV_TX_RISE, EV_TX_FALL, EV_SQ_RISE, EV_SQ_FALL,
    EV_RX_RISE, EV_RX_FALL, EV_TOF, EV_NOECHO, EV_BUSY_FALL
  } ev_kind_t;

  typedef struct {
    ev_kind_t kind;
    int       cyc;
    int       val;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  bit  mon_en = 1'b0;
  logic p_tx, p_sq, p_rx, p_busy;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input ev_kind_t k, input int c, input int v);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_t k, input int v);
    int idx = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].kind == k) begin
        idx = i;
        break;
      end
    end
    if (idx < 0) begin
      total++;
      bad++;
      $display("FAIL unexpected %s at cycle %0d (value %0d)", k.name(), cyc, v);
    end else begin
      check({k.name(), " cycle"}, cyc, exp_q[idx].cyc);
      if (k == EV_TOF || k == EV_NOECHO) check({k.name(), " value"}, v, exp_q[idx].val);
      exp_q.delete(idx);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (tx_en && !p_tx)      observe(EV_TX_RISE, 0);
      if (!tx_en && p_tx)      observe(EV_TX_FALL, 0);
      if (tx_square && !p_sq)  observe(EV_SQ_RISE, 0);
      if (!tx_square && p_sq)  observe(EV_SQ_FALL, 0);
      if (rx_gate && !p_rx)    observe(EV_RX_RISE, 0);
      if (!rx_gate && p_rx)    observe(EV_RX_FALL, 0);
      if (tof_valid)           observe(EV_TOF, int'(tof_cycles));
      if (no_echo)             observe(EV_NOECHO, int'(tof_cycles));
      if (!busy && p_busy)     observe(EV_BUSY_FALL, 0);
    end
    p_tx   <= tx_en;
    p_sq   <= tx_square;
    p_rx   <= rx_gate;
    p_busy <= busy;
  end

  // Ping whose start is sampled at edge b+1: TX b+1..b+20, BLANK b+21..b+30,
  // LISTEN from b+31 (tof = rel-1), GAP 5 cycles after the listen window ends.
  task automatic push_ping(input int b, input bit echo, input int tofv, input bit idle_end);
    int e;
    expect_ev(EV_TX_RISE, b + 1, 0);
    expect_ev(EV_SQ_RISE, b + 1, 0);
    expect_ev(EV_SQ_FALL, b + 6, 0);
    expect_ev(EV_SQ_RISE, b + 11, 0);
    expect_ev(EV_SQ_FALL, b + 16, 0);
    expect_ev(EV_TX_FALL, b + 21, 0);
    expect_ev(EV_RX_RISE, b + 31, 0);
    e = echo ? (b + tofv + 2) : (b + 81);
    expect_ev(EV_RX_FALL, e, 0);
    expect_ev(echo ? EV_TOF : EV_NOECHO, e, tofv);
    if (idle_end) expect_ev(EV_BUSY_FALL, e + 5, 0);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " tx_en"},      int'(tx_en), 0);
    check({tag, " tx_square"},  int'(tx_square), 0);
    check({tag, " rx_gate"},    int'(rx_gate), 0);
    check({tag, " busy"},       int'(busy), 0);
    check({tag, " tof_valid"},  int'(tof_valid), 0);
    check({tag, " no_echo"},    int'(no_echo), 0);
    check({tag, " tof_cycles"}, int'(tof_cycles), 0);
  endtask

  initial begin
    int b, b2, b3;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // Timeout: no echo at all, tof_cycles still 0 from reset.
    @(negedge clk); b = cyc;
    push_ping(b, 1'b0, 0, 1'b1);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_cyc(b + 95);

    // Blanking: echo held through the last BLANK cycle, gone in LISTEN.
    b = cyc;
    push_ping(b, 1'b0, 0, 1'b1);
    start = 1'b1; echo_in = 1'b1; @(negedge clk); start = 1'b0;
    wait_cyc(b + 31); echo_in = 1'b0;
    wait_cyc(b + 95);

    // Single ping, echo while tof counter = 40.
    b = cyc;
    push_ping(b, 1'b1, 40, 1'b1);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_cyc(b + 41); echo_in = 1'b1;
    wait_cyc(b + 42); echo_in = 1'b0;
    wait_cyc(b + 60);

    // Extra starts in TX and LISTEN ignored; echo in the final LISTEN cycle.
    b = cyc;
    push_ping(b, 1'b1, 79, 1'b1);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_cyc(b + 5);  start = 1'b1;
    wait_cyc(b + 6);  start = 1'b0;
    wait_cyc(b + 40); start = 1'b1;
    wait_cyc(b + 41); start = 1'b0;
    wait_cyc(b + 80); echo_in = 1'b1;
    wait_cyc(b + 81); echo_in = 1'b0;
    wait_cyc(b + 110);

    // Reset during cycle 8 of TX.
    b = cyc;
    expect_ev(EV_TX_RISE, b + 1, 0);
    expect_ev(EV_SQ_RISE, b + 1, 0);
    expect_ev(EV_SQ_FALL, b + 6, 0);
    expect_ev(EV_TX_FALL, b + 9, 0);
    expect_ev(EV_BUSY_FALL, b + 9, 0);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_cyc(b + 8); rst = 1'b1;
    wait_cyc(b + 9); rst = 1'b0;
    check_all_zero("after abort");
    wait_cyc(b + 12);

    // Fresh ping after the abort; echo in the first LISTEN cycle.
    b = cyc;
    push_ping(b, 1'b1, 30, 1'b1);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_cyc(b + 31); echo_in = 1'b1;
    wait_cyc(b + 32); echo_in = 1'b0;
    wait_cyc(b + 50);

    // Continuous mode (start raised together with it): three pings.
    b = cyc;
    b2 = b + 39;
    b3 = b2 + 85;
    push_ping(b, 1'b1, 33, 1'b0);
    push_ping(b2, 1'b0, 33, 1'b0);
    push_ping(b3, 1'b1, 70, 1'b1);
    start = 1'b1; continuous = 1'b1; @(negedge clk); start = 1'b0;
    wait_cyc(b + 34);  echo_in = 1'b1;
    wait_cyc(b + 35);  echo_in = 1'b0;
    wait_cyc(b3 + 50); continuous = 1'b0;
    wait_cyc(b3 + 71); echo_in = 1'b1;
    wait_cyc(b3 + 72); echo_in = 1'b0;
    wait_cyc(b3 + 110);

    check("leftover expected events", exp_q.size(), 0);
    foreach (exp_q[i]) $display("  missing %s at cycle %0d", exp_q[i].kind.name(), exp_q[i].cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
